best_arr_serializer: RTL and testbench
======================================

Name: best_arr_serializer

Overview:
Output-side stage of the kd-tree ANN accelerator. It drains the per-query best-match array into the 11-bit output FIFO that feeds the out_fifo_rdata GPIO pins. It is started by the send_best_arr pin. For each query it reads one best-array entry and emits it as three 11-bit words: the index word, then the high distance word, then the low distance word.

Parameters:
DATA_WIDTH, 11, output FIFO word width; must be >= IDX_WIDTH.
NUM_QUERYS, 494, number of best-array entries (ROW_SIZE*COL_SIZE = 26*19).
NUM_LEAVES, 64, leaves in the kd-tree; LEAF_W = $clog2(NUM_LEAVES) = 6.
LEAF_SIZE, 8, points per leaf; PT_W = $clog2(LEAF_SIZE) = 3.
IDX_WIDTH, LEAF_W+PT_W = 9, width of the best-match index.
DIST_WIDTH, 2*DATA_WIDTH = 22, width of the best-match distance.
QADDR_WIDTH, $clog2(NUM_QUERYS) = 9, best-array address width.

Ports:
io_clk  input  1  clock.
io_rst_n  input  1  asynchronous active-low reset.
send_best_arr  input  1  start level/pulse; sampled only in IDLE.
busy  output  1  high from the first cycle after start until the done cycle.
done  output  1  one-cycle pulse after the last word is accepted.
mem_rd_en  output  1  best-array read enable.
mem_addr  output  QADDR_WIDTH  best-array read address.
mem_rdata_idx  input  IDX_WIDTH  {leaf_idx[5:0], point_idx[2:0]}; valid 1 cycle after mem_rd_en.
mem_rdata_dist  input  DIST_WIDTH  best distance; valid 1 cycle after mem_rd_en.
out_fifo_wenq  output  1  output FIFO enqueue.
out_fifo_wdata  output  DATA_WIDTH  output FIFO data.
out_fifo_wfull_n  input  1  output FIFO not-full.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, query counter q=0, holding regs=0, busy=0, done=0, mem_rd_en=0, mem_addr=0, out_fifo_wenq=0, out_fifo_wdata=0.
- A reset asserted mid-transfer aborts the transfer. No done pulse is generated. Words already enqueued stay in the FIFO.
- States: IDLE, READ, CAPT, W0, W1, W2, FIN.
- IDLE: if send_best_arr=1, set q<=0 and go to READ. Otherwise stay.
- READ: mem_rd_en=1, mem_addr=q for exactly one cycle, then go to CAPT.
- CAPT: latch hold_idx<=mem_rdata_idx and hold_dist<=mem_rdata_dist, then go to W0. The read latency of exactly 1 cycle is fixed.
- W0: out_fifo_wdata={(DATA_WIDTH-IDX_WIDTH)'b0, hold_idx}.
- W1: out_fifo_wdata=hold_dist[21:11].
- W2: out_fifo_wdata=hold_dist[10:0].
- In W0/W1/W2: out_fifo_wenq = out_fifo_wfull_n (combinational from state), so every wenq cycle is an accepted word.
  - Advance to the next state only on accept. While wfull_n=0, hold state and keep wdata stable.
- W2 on accept:
  - if q==NUM_QUERYS-1, go to FIN;
  - else q<=q+1 and go to READ.
- FIN: done=1 for one cycle, busy=0 in that cycle, then go to IDLE.
- busy=1 in READ, CAPT, W0, W1, W2.
- Throughput: 5 cycles per query with no backpressure. A full transfer is 494*5+1 = 2471 cycles from the first READ to done, inclusive.
- send_best_arr is ignored outside IDLE. A start held high through FIN re-arms on the IDLE cycle that follows.
- Total words emitted per transfer: 3*NUM_QUERYS = 1482. No header and no trailer.
- The counter never wraps. q stops at NUM_QUERYS-1, and mem_addr never exceeds 493.
- mem_rd_en is never asserted outside READ, and mem_addr is don't-care when mem_rd_en=0. Addresses follow the strictly increasing sequence 0..493.

Test Plan:
- Basic order: memory entry q holds idx=q[8:0] and dist=22'h2AAAAA^q; wfull_n=1; pulse start. Expect 1482 words in the order (q, dist[21:11], dist[10:0]) for each q. Expect done exactly once, 2471 cycles after the first READ, with busy low in that cycle.
- Backpressure: toggle wfull_n pseudo-randomly (~50%). Expect the same 1482-word sequence, no wenq while wfull_n=0, and wdata stable across each stall.
- Edge values: entry 0 = {idx=9'h1FF, dist=22'h3FFFFF}; entry 493 = {idx=0, dist=0}. Expect words 11'h1FF, 11'h7FF, 11'h7FF first, and 11'h000 ×3 last.
- Start while busy: pulse send_best_arr mid-transfer and hold it high through FIN. Expect a single uninterrupted 1482-word stream, then a second transfer starting right after the IDLE cycle.
- Reset mid-op: assert io_rst_n=0 asynchronously during W1 of q=100. Expect all outputs 0 immediately and no done. A new start after reset begins at mem_addr=0.
- Stall on the last word: hold wfull_n=0 in W2 of q=493 for 50 cycles. Expect done only after that word is accepted, and busy held high throughout the stall.

Source files
------------

// File: rtl/best_arr_serializer.sv
// Drains the per-query best-match array into the 11-bit output FIFO.
// Each entry is sent as three words: the index, then the high and low halves of the distance.
module best_arr_serializer #(
    parameter int unsigned  DATA_WIDTH  = 11,
    parameter int unsigned  NUM_QUERYS  = 494,
    parameter int unsigned  NUM_LEAVES  = 64,
    parameter int unsigned  LEAF_SIZE   = 8,
    localparam int unsigned LEAF_W      = $clog2(NUM_LEAVES),
    localparam int unsigned PT_W        = $clog2(LEAF_SIZE),
    localparam int unsigned IDX_WIDTH   = LEAF_W + PT_W,
    localparam int unsigned DIST_WIDTH  = 2 * DATA_WIDTH,
    localparam int unsigned QADDR_WIDTH = $clog2(NUM_QUERYS)
) (
    input  logic                   io_clk,
    input  logic                   io_rst_n,
    input  logic                   send_best_arr,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [QADDR_WIDTH-1:0] mem_addr,
    input  logic [IDX_WIDTH-1:0]   mem_rdata_idx,
    input  logic [DIST_WIDTH-1:0]  mem_rdata_dist,
    output logic                   out_fifo_wenq,
    output logic [DATA_WIDTH-1:0]  out_fifo_wdata,
    input  logic                   out_fifo_wfull_n
);

    localparam logic [QADDR_WIDTH-1:0] Q_LAST = QADDR_WIDTH'(NUM_QUERYS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_W0,
        S_W1,
        S_W2,
        S_FIN
    } state_e;

    state_e                 state;
    logic [QADDR_WIDTH-1:0] q;
    logic [DIST_WIDTH-1:0]  hold_dist;
    logic                   in_word;

    // Enqueue whenever a word is presented and the FIFO can take it, so every wenq is an accept.
    assign in_word       = (state == S_W0) || (state == S_W1) || (state == S_W2);
    assign out_fifo_wenq = in_word && out_fifo_wfull_n;

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state          <= S_IDLE;
            q              <= '0;
            hold_dist      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_addr       <= '0;
            out_fifo_wdata <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (send_best_arr) begin
                        q         <= '0;
                        mem_addr  <= '0;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ: state <= S_CAPT;
                // Read data is valid exactly one cycle after the read strobe.
                S_CAPT: begin
                    hold_dist      <= mem_rdata_dist;
                    out_fifo_wdata <= DATA_WIDTH'(mem_rdata_idx);
                    state          <= S_W0;
                end
                S_W0: begin
                    if (out_fifo_wfull_n) begin
                        out_fifo_wdata <= hold_dist[DIST_WIDTH-1:DATA_WIDTH];
                        state          <= S_W1;
                    end
                end
                S_W1: begin
                    if (out_fifo_wfull_n) begin
                        out_fifo_wdata <= hold_dist[DATA_WIDTH-1:0];
                        state          <= S_W2;
                    end
                end
                S_W2: begin
                    if (out_fifo_wfull_n) begin
                        if (q == Q_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            q         <= q + QADDR_WIDTH'(1);
                            mem_addr  <= q + QADDR_WIDTH'(1);
                            mem_rd_en <= 1'b1;
                            state     <= S_READ;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_best_arr_serializer.sv
// Self-checking bench for best_arr_serializer: table-driven transfers, hand-written corner
// sequences, and a word-stream reference built directly from the memory contents.
module tb_best_arr_serializer;

    localparam int NQ    = 494;
    localparam int NWORD = 3 * NQ;

    logic        io_clk = 1'b0;
    logic        io_rst_n;
    logic        send_best_arr;
    logic        busy, done, mem_rd_en, out_fifo_wenq, out_fifo_wfull_n;
    logic [8:0]  mem_addr;
    logic [8:0]  mem_rdata_idx;
    logic [21:0] mem_rdata_dist;
    logic [10:0] out_fifo_wdata;

    best_arr_serializer dut (
        .io_clk           (io_clk),
        .io_rst_n         (io_rst_n),
        .send_best_arr    (send_best_arr),
        .busy             (busy),
        .done             (done),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rdata_idx    (mem_rdata_idx),
        .mem_rdata_dist   (mem_rdata_dist),
        .out_fifo_wenq    (out_fifo_wenq),
        .out_fifo_wdata   (out_fifo_wdata),
        .out_fifo_wfull_n (out_fifo_wfull_n)
    );

    always #5 io_clk = ~io_clk;

    logic [8:0]  mem_idx  [512];
    logic [21:0] mem_dist [512];

    // Best-array memory: one-cycle read latency.
    always @(posedge io_clk) begin
        if (mem_rd_en) begin
            mem_rdata_idx  <= mem_idx[mem_addr];
            mem_rdata_dist <= mem_dist[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] got[$];
    logic [10:0] exp_q[$];
    int cyc = 0, rd_cnt, first_rd_cyc, done_cnt, done_cyc, addr_err, wenq_err, stab_err;
    int busy_done_err, stall_n, stall_err, nw;
    bit in_words, have_stall;
    logic [1:0]  pipe;
    logic [10:0] stall_val;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Protocol monitor: words, addresses, done, stalls. Word phase begins two cycles after a read.
    always @(negedge io_clk) begin
        cyc++;
        if (!io_rst_n) begin
            in_words   = 1'b0;
            have_stall = 1'b0;
            pipe       = 2'b00;
        end else begin
            if (pipe[1]) begin
                in_words = 1'b1;
                nw       = 0;
            end
            if (out_fifo_wenq && (!out_fifo_wfull_n || !in_words)) wenq_err++;
            if (in_words) begin
                if (have_stall && out_fifo_wdata !== stall_val) stab_err++;
                if (!out_fifo_wfull_n) begin
                    have_stall = 1'b1;
                    stall_val  = out_fifo_wdata;
                end else begin
                    have_stall = 1'b0;
                end
                if (out_fifo_wenq) begin
                    nw++;
                    if (nw == 3) in_words = 1'b0;
                end
            end
            if (out_fifo_wenq) got.push_back(out_fifo_wdata);
            if (mem_rd_en) begin
                if (rd_cnt == 0) first_rd_cyc = cyc;
                if (mem_addr != 9'(rd_cnt)) addr_err++;
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) busy_done_err++;
            end
            pipe = {pipe[0], mem_rd_en};
        end
    end

    task automatic clear_mon();
        got.delete();
        rd_cnt = 0; done_cnt = 0; addr_err = 0; wenq_err = 0; stab_err = 0;
        busy_done_err = 0; stall_n = 0; stall_err = 0; first_rd_cyc = 0;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 512; i++) begin
            if (rnd) begin
                mem_idx[i]  = 9'($urandom);
                mem_dist[i] = 22'($urandom);
            end else begin
                mem_idx[i]  = 9'(i);
                mem_dist[i] = 22'h2AAAAA ^ 22'(i);
            end
        end
    endtask

    // Reference stream: per entry, index then distance split into base-2048 digits.
    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < NQ; i++) begin
            exp_q.push_back(11'(mem_idx[i]));
            exp_q.push_back(11'(int'(mem_dist[i]) / 2048));
            exp_q.push_back(11'(int'(mem_dist[i]) % 2048));
        end
    endtask

    task automatic start_xfer();
        @(posedge io_clk); #1 send_best_arr = 1'b1;
        @(posedge io_clk); #1 send_best_arr = 1'b0;
    endtask

    task automatic wait_done(input int bp_pct, input bit stall_last, input int mid_at, input bit hold);
        int c;
        c = 0;
        while (done_cnt == 0 && c < 20000) begin
            @(posedge io_clk); #1;
            if (c == mid_at) send_best_arr = 1'b1;
            else if (c == mid_at + 1 && !hold) send_best_arr = 1'b0;
            if (stall_last && got.size() == NWORD - 1 && stall_n < 50) begin
                out_fifo_wfull_n = 1'b0;
                stall_n++;
                @(negedge io_clk);
                if (!busy || done) stall_err++;
            end else begin
                out_fifo_wfull_n = ($urandom_range(99) >= bp_pct);
            end
            c++;
        end
        out_fifo_wfull_n = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int exp_cycles);
        int mis;
        mis = -1;
        for (int i = 0; i < NWORD; i++)
            if (mis < 0 && (i >= got.size() || got[i] !== exp_q[i])) mis = i;
        chk({tag, "_word_count"}, got.size(), NWORD);
        chk({tag, "_first_bad_word"}, mis, -1);
        chk({tag, "_reads"}, rd_cnt, NQ);
        chk({tag, "_addr_seq_err"}, addr_err, 0);
        chk({tag, "_wenq_err"}, wenq_err, 0);
        chk({tag, "_stall_stable_err"}, stab_err, 0);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_busy_at_done"}, busy_done_err, 0);
        if (exp_cycles > 0) chk({tag, "_cycles"}, done_cyc - first_rd_cyc + 1, exp_cycles);
    endtask

    function automatic int word_at(int i);
        return (i < got.size()) ? int'(got[i]) : -1;
    endfunction

    typedef struct {
        string       name;
        bit          rnd;
        int          bp_pct;
        int          exp_cycles;
        logic [8:0]  idx0, idxl;
        logic [21:0] dist0, distl;
        logic [10:0] f0, f1, f2, l0, l1, l2;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int prev_done;
        vecs[0] = '{"basic", 1'b0, 0, 2471, 9'h000, 9'h1ED, 22'h2AAAAA, 22'h2AAB47,
                    11'h000, 11'h555, 11'h2AA, 11'h1ED, 11'h555, 11'h347};
        vecs[1] = '{"edge_bp", 1'b0, 50, 0, 9'h1FF, 9'h000, 22'h3FFFFF, 22'h000000,
                    11'h1FF, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 11'h000};
        vecs[2] = '{"rand_bp", 1'b1, 25, 0, 9'h155, 9'h0AA, 22'h000800, 22'h0007FF,
                    11'h155, 11'h001, 11'h000, 11'h0AA, 11'h000, 11'h7FF};

        io_rst_n = 1'b0; send_best_arr = 1'b0; out_fifo_wfull_n = 1'b1;
        clear_mon();
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wenq", out_fifo_wenq, 0);
        chk("reset_wdata", out_fifo_wdata, 0);
        repeat (3) @(posedge io_clk);
        #1 io_rst_n = 1'b1;

        foreach (vecs[v]) begin
            fill_mem(vecs[v].rnd);
            mem_idx[0] = vecs[v].idx0;  mem_dist[0] = vecs[v].dist0;
            mem_idx[NQ-1] = vecs[v].idxl; mem_dist[NQ-1] = vecs[v].distl;
            build_exp();
            clear_mon();
            start_xfer();
            wait_done(vecs[v].bp_pct, 1'b0, -1, 1'b0);
            check_stream(vecs[v].name, vecs[v].exp_cycles);
            chk({vecs[v].name, "_w0"}, word_at(0), int'(vecs[v].f0));
            chk({vecs[v].name, "_w1"}, word_at(1), int'(vecs[v].f1));
            chk({vecs[v].name, "_w2"}, word_at(2), int'(vecs[v].f2));
            chk({vecs[v].name, "_wl0"}, word_at(NWORD - 3), int'(vecs[v].l0));
            chk({vecs[v].name, "_wl1"}, word_at(NWORD - 2), int'(vecs[v].l1));
            chk({vecs[v].name, "_wl2"}, word_at(NWORD - 1), int'(vecs[v].l2));
            repeat (2) @(posedge io_clk);
        end

        // Start pulsed mid-transfer then held through FIN: one clean stream, re-arm after IDLE.
        fill_mem(1'b1);
        build_exp();
        clear_mon();
        start_xfer();
        wait_done(0, 1'b0, 500, 1'b1);
        check_stream("start_busy", 2471);
        prev_done = done_cyc;
        clear_mon();
        @(posedge io_clk); #1 send_best_arr = 1'b0;
        wait_done(0, 1'b0, -1, 1'b0);
        check_stream("rearm", 2471);
        chk("rearm_gap", first_rd_cyc - prev_done, 2);
        repeat (2) @(posedge io_clk);

        // Asynchronous reset during W1 of q=100.
        fill_mem(1'b0);
        build_exp();
        clear_mon();
        start_xfer();
        for (int c = 0; c < 5000 && got.size() != 301; c++) begin
            @(posedge io_clk); #1;
        end
        chk("rst_mid_reached", got.size(), 301);
        io_rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_rd_en", mem_rd_en, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wenq", out_fifo_wenq, 0);
        chk("rst_mid_wdata", out_fifo_wdata, 0);
        repeat (5) @(negedge io_clk);
        @(posedge io_clk); #1 io_rst_n = 1'b1;
        repeat (5) @(negedge io_clk);
        chk("rst_mid_no_done", done_cnt, 0);
        clear_mon();
        start_xfer();
        wait_done(0, 1'b0, -1, 1'b0);
        check_stream("after_rst", 2471);
        repeat (2) @(posedge io_clk);

        // 50-cycle stall on the very last word.
        fill_mem(1'b1);
        build_exp();
        clear_mon();
        start_xfer();
        wait_done(0, 1'b1, -1, 1'b0);
        check_stream("stall_last", 2521);
        chk("stall_last_cycles_held", stall_n, 50);
        chk("stall_last_busy_err", stall_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
